conv_seq_ctrl: RTL and testbench
================================

Name: conv_seq_ctrl

Overview:
- Sequencer for the sliding-window convolution datapath: X shift memory, F memory, parallel multiply/adder tree and registered output accumulator.
- Admits X samples over the AXI-style slave handshake and pulses the accumulator capture once per window.
- Drives the Y master handshake and prefetches the next X sample while Y is stalled.
- Pulses conv_done after the last output so the F-memory write controller re-arms.

Parameters:
- X_SIZE, 128, total X samples per convolution.
- F_SIZE, 32, filter taps (window length).
- X_CNT_W, $clog2(X_SIZE)+1, counter width for x_count and y_index.

Ports:
- clk  input  1  single clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low; asserting forces reset state immediately, release is sampled at clk.
- s_valid_x  input  1  X sample valid from upstream.
- f_loaded  input  1  F memory holds all F_SIZE taps (level, from F write controller).
- m_ready_y  input  1  downstream accepts Y.
- s_ready_x  output  1  X sample may be accepted this cycle.
- xmem_wr_en  output  1  s_valid_x & s_ready_x; shifts X memory.
- x_count  output  X_CNT_W  X samples accepted this convolution (0..X_SIZE).
- acc_load  output  1  one-cycle pulse; accumulator captures adder-tree sum.
- m_valid_y  output  1  Y valid (accumulator output is stable).
- y_index  output  X_CNT_W  index of the Y currently offered (0..X_SIZE-F_SIZE).
- conv_done  output  1  one-cycle pulse after last Y handshake.

Behaviour:
- Reset (reset=0): state=FILL, x_count=0, y_index=0, pref=0. All outputs 0 while reset is held. After release, s_ready_x=1 in FILL.
- Outputs decoded from registered state/flags. s_ready_x never depends on s_valid_x.
- NOUT = X_SIZE-F_SIZE+1.
- FILL:
  - s_ready_x = (x_count<F_SIZE). Each accepted sample increments x_count.
  - When x_count==F_SIZE and f_loaded=1, go to CAPTURE.
  - If x_count==F_SIZE and f_loaded=0: hold in FILL, s_ready_x=0.
- CAPTURE: acc_load=1 for exactly one cycle, s_ready_x=0, next state OUTPUT.
- OUTPUT:
  - m_valid_y=1, held until m_ready_y=1. Y data is stable because it comes from the registered accumulator.
  - s_ready_x = ~pref & (y_index<NOUT-1). An accept sets pref, increments x_count and shifts the memory; this is legal because the captured Y is already registered.
  - On the handshake cycle, y_index increments, then:
    - if y_index was NOUT-1, go to DONE;
    - else if pref, or an X sample is accepted in the same cycle, go to CAPTURE and clear pref;
    - else go to SLIDE.
- SLIDE: s_ready_x=1. On accept, x_count increments and the next state is CAPTURE.
- DONE:
  - conv_done=1 for one cycle, all other outputs 0.
  - x_count, y_index and pref clear.
  - Next state FILL.
- Latency:
  - acc_load to m_valid_y is 1 cycle.
  - Steady state with m_ready_y=1 and X always valid: 1 Y every 2 cycles (CAPTURE, OUTPUT with prefetch).
- Invariants:
  - x_count never exceeds X_SIZE.
  - x_count == F_SIZE+y_index at every CAPTURE.
  - The final window receives no prefetch, so no X sample leaks into the next convolution.
- Simultaneous X accept and Y handshake in OUTPUT: both take effect, next state is CAPTURE.
- f_loaded falling mid-convolution is ignored; it is checked only in FILL.
- Reset asserted mid-operation: immediate return to the reset state. An in-flight Y is dropped, m_valid_y=0, and no conv_done is generated.

Test Plan:
- X_SIZE=8, F_SIZE=3, f_loaded=1, s_valid_x=1, m_ready_y=1 -> x_count reaches 3 after 3 accepts; acc_load, then m_valid_y next cycle; 6 Y handshakes with y_index 0..5; conv_done pulses once; exactly 8 xmem_wr_en pulses.
- Same config, f_loaded=0 until cycle 10 -> s_ready_x=0 once x_count==3; first acc_load on the cycle after f_loaded rises.
- m_ready_y held 0 for 5 cycles at y_index=2 -> m_valid_y stays 1; exactly one X accepted (pref), then no further X. On release: CAPTURE directly, no SLIDE cycle, y_index=3.
- Last window (y_index=5) stalled -> s_ready_x stays 0; x_count stays 8; conv_done follows the handshake by one cycle; next cycle FILL with s_ready_x=1 and x_count=0.
- s_valid_x low during SLIDE for 4 cycles -> no acc_load until the accept; m_valid_y=0 throughout.
- reset asserted asynchronously while m_valid_y=1 at y_index=3 -> all outputs 0 immediately, no conv_done; after release, a full 6-output run completes.

Source files
------------

// File: rtl/conv_seq_ctrl.sv
// Sequencer for the sliding-window convolution datapath: admits X samples, pulses the
// accumulator capture once per window, drives the Y handshake and prefetches the next X.
module conv_seq_ctrl #(
    parameter int X_SIZE  = 128,
    parameter int F_SIZE  = 32,
    parameter int X_CNT_W = $clog2(X_SIZE) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid_x,
    input  logic               f_loaded,
    input  logic               m_ready_y,
    output logic               s_ready_x,
    output logic               xmem_wr_en,
    output logic [X_CNT_W-1:0] x_count,
    output logic               acc_load,
    output logic               m_valid_y,
    output logic [X_CNT_W-1:0] y_index,
    output logic               conv_done
);

    localparam logic [2:0] S_FILL    = 3'd0;
    localparam logic [2:0] S_CAPTURE = 3'd1;
    localparam logic [2:0] S_OUTPUT  = 3'd2;
    localparam logic [2:0] S_SLIDE   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [X_CNT_W-1:0] F_CNT  = X_CNT_W'(F_SIZE);
    localparam logic [X_CNT_W-1:0] LAST_Y = X_CNT_W'(X_SIZE - F_SIZE);
    localparam logic [X_CNT_W-1:0] ONE    = X_CNT_W'(1);

    logic [2:0]         r_state;
    logic [X_CNT_W-1:0] r_x_count;
    logic [X_CNT_W-1:0] r_y_index;
    logic               r_pref;
    logic               r_active;
    logic               w_ready;
    logic               w_accept;

    // X-side ready, decoded from registered state only; r_active keeps it low while reset is held
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            S_FILL:   w_ready = r_active & (r_x_count < F_CNT);
            S_OUTPUT: w_ready = ~r_pref & (r_y_index < LAST_Y);
            S_SLIDE:  w_ready = 1'b1;
            default:  w_ready = 1'b0;
        endcase
    end

    assign w_accept   = s_valid_x & w_ready;
    assign s_ready_x  = w_ready;
    assign xmem_wr_en = w_accept;
    assign x_count    = r_x_count;
    assign y_index    = r_y_index;
    assign acc_load   = (r_state == S_CAPTURE);
    assign m_valid_y  = (r_state == S_OUTPUT);
    assign conv_done  = (r_state == S_DONE);

    // Window sequencing, sample/output counters and the prefetch flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FILL;
            r_x_count <= '0;
            r_y_index <= '0;
            r_pref    <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_active <= 1'b1;
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        r_x_count <= r_x_count + ONE;
                    end
                    if ((r_x_count == F_CNT) && f_loaded) begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_state <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (w_accept) begin
                        r_x_count <= r_x_count + ONE;
                    end
                    if (m_ready_y) begin
                        if (r_y_index == LAST_Y) begin
                            r_state   <= S_DONE;
                            r_x_count <= '0;
                            r_y_index <= '0;
                            r_pref    <= 1'b0;
                        end else begin
                            r_y_index <= r_y_index + ONE;
                            r_pref    <= 1'b0;
                            r_state   <= (r_pref | w_accept) ? S_CAPTURE : S_SLIDE;
                        end
                    end else if (w_accept) begin
                        // Y is already registered, so the window may shift underneath it
                        r_pref <= 1'b1;
                    end
                end
                S_SLIDE: begin
                    if (w_accept) begin
                        r_x_count <= r_x_count + ONE;
                        r_state   <= S_CAPTURE;
                    end
                end
                S_DONE: begin
                    r_state   <= S_FILL;
                    r_x_count <= '0;
                    r_y_index <= '0;
                    r_pref    <= 1'b0;
                end
                default: begin
                    r_state   <= S_FILL;
                    r_x_count <= '0;
                    r_y_index <= '0;
                    r_pref    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl (X_SIZE=8, F_SIZE=3): directed scenarios followed by random
// handshakes, all checked by a transaction-level monitor of counts, indices and pulse order.
module tb_conv_seq_ctrl;
    localparam int XS   = 8;
    localparam int FS   = 3;
    localparam int NOUT = XS - FS + 1;
    localparam int W    = $clog2(XS) + 1;

    logic         clk = 1'b0;
    logic         reset, s_valid_x, f_loaded, m_ready_y;
    logic         s_ready_x, xmem_wr_en, acc_load, m_valid_y, conv_done;
    logic [W-1:0] x_count, y_index;

    int total = 0;
    int bad   = 0;
    logic g_rst, g_vx, g_fl, g_ry;
    int n_wr, exp_y, stall_acc, n_acc, n_hs, n_done, cyc_no, first_acc_cyc, done_cyc;
    bit prev_acc, prev_valid, prev_last_hs;
    int a0, h0, d0, w0;

    conv_seq_ctrl #(.X_SIZE(XS), .F_SIZE(FS)) dut (
        .clk(clk), .reset(reset), .s_valid_x(s_valid_x), .f_loaded(f_loaded),
        .m_ready_y(m_ready_y), .s_ready_x(s_ready_x), .xmem_wr_en(xmem_wr_en),
        .x_count(x_count), .acc_load(acc_load), .m_valid_y(m_valid_y),
        .y_index(y_index), .conv_done(conv_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        n_wr = 0; exp_y = 0; stall_acc = 0;
        prev_acc = 1'b0; prev_valid = 1'b0; prev_last_hs = 1'b0;
    endtask

    // Reference: x_count = samples accepted this convolution, Y offered in order 0..NOUT-1,
    // capture sees F_SIZE+Y samples, at most one accept per offered Y, done after the last Y
    task automatic monitor();
        bit last_hs;
        last_hs = 1'b0;
        if (!reset) begin
            model_clear();
            return;
        end
        if (conv_done) begin
            chk("done_xcount", x_count, 0);
            chk("done_yindex", y_index, 0);
            chk("done_writes", n_wr, XS);
            chk("done_quiet", {s_ready_x, acc_load, m_valid_y}, 0);
            n_wr = 0; n_done++; done_cyc = cyc_no;
        end else begin
            chk("x_count", x_count, n_wr);
        end
        if (conv_done || prev_last_hs) chk("done_follows_last_y", conv_done, prev_last_hs);
        chk("wr_en", xmem_wr_en, s_valid_x & s_ready_x);
        if (acc_load) begin
            chk("capture_xcount", x_count, FS + exp_y);
            chk("capture_no_ready", s_ready_x, 0);
            n_acc++;
            if (exp_y == 0) first_acc_cyc = cyc_no;
        end
        if (prev_acc) chk("acc_to_valid", m_valid_y, 1);
        if (m_valid_y && !prev_valid) begin
            chk("valid_src", prev_acc, 1);
            stall_acc = 0;
        end
        if (m_valid_y) begin
            chk("y_index", y_index, exp_y);
            if (xmem_wr_en) begin
                stall_acc++;
                chk("prefetch_once", stall_acc, 1);
                chk("no_last_prefetch", exp_y < NOUT - 1, 1);
            end
            if (m_ready_y) begin
                n_hs++;
                last_hs = (exp_y == NOUT - 1);
                exp_y   = last_hs ? 0 : exp_y + 1;
            end
        end
        if (xmem_wr_en) n_wr++;
        prev_acc = acc_load; prev_valid = m_valid_y; prev_last_hs = last_hs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        reset = g_rst; s_valid_x = g_vx; f_loaded = g_fl; m_ready_y = g_ry;
        cyc_no++;
        @(negedge clk);
        monitor();
    endtask

    task automatic wait_capture(input int y);
        for (int k = 0; k < 300; k++) begin
            tick();
            if (acc_load && (y_index == y)) break;
        end
        chk("capture_reached", acc_load && (y_index == y), 1);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 300; k++) begin
            tick();
            if (conv_done) break;
        end
        chk("done_reached", conv_done, 1);
    endtask

    initial begin
        reset = 1'b0; s_valid_x = 1'b0; f_loaded = 1'b0; m_ready_y = 1'b0;
        g_rst = 1'b0; g_vx = 1'b1; g_fl = 1'b1; g_ry = 1'b1;
        n_acc = 0; n_hs = 0; n_done = 0; cyc_no = 0; first_acc_cyc = 0; done_cyc = 0;
        model_clear();

        // reset held with valid inputs present
        tick(); tick();
        chk("rst_ready", s_ready_x, 0);
        chk("rst_wr_en", xmem_wr_en, 0);
        chk("rst_acc", acc_load, 0);
        chk("rst_valid", m_valid_y, 0);
        chk("rst_done", conv_done, 0);
        chk("rst_xcount", x_count, 0);
        chk("rst_yindex", y_index, 0);

        // full run, everything streaming
        g_rst = 1'b1;
        tick(); tick();
        chk("fill_ready", s_ready_x, 1);
        chk("fill_xcount", x_count, 0);
        a0 = n_acc; h0 = n_hs; d0 = n_done;
        wait_done();
        chk("run_captures", n_acc - a0, NOUT);
        chk("run_handshakes", n_hs - h0, NOUT);
        chk("run_dones", n_done - d0, 1);
        chk("run_throughput", done_cyc - first_acc_cyc, 2 * NOUT);
        tick();
        chk("post_done_ready", s_ready_x, 1);
        chk("post_done_xcount", x_count, 0);

        // f_loaded low: fill stops at F_SIZE and waits
        g_fl = 1'b0; a0 = n_acc;
        for (int i = 0; i < 10; i++) tick();
        chk("fl_wait_ready", s_ready_x, 0);
        chk("fl_wait_xcount", x_count, FS);
        chk("fl_wait_noacc", n_acc - a0, 0);
        g_fl = 1'b1;
        tick();
        chk("fl_rise_noacc", acc_load, 0);
        tick();
        chk("fl_first_acc", acc_load, 1);

        // Y stalled at index 2: one prefetch, then capture directly on release
        wait_capture(2);
        g_ry = 1'b0; w0 = n_wr;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", m_valid_y, 1);
            chk("stall_yindex", y_index, 2);
        end
        chk("stall_one_pref", n_wr - w0, 1);
        chk("stall_ready", s_ready_x, 0);
        g_ry = 1'b1;
        tick();
        tick();
        chk("stall_release_acc", acc_load, 1);
        chk("stall_release_yindex", y_index, 3);

        // last window stalled: no prefetch, then done and back to fill
        wait_capture(NOUT - 1);
        g_ry = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("last_valid", m_valid_y, 1);
            chk("last_ready", s_ready_x, 0);
            chk("last_xcount", x_count, XS);
        end
        g_ry = 1'b1;
        tick();
        chk("last_hs_nodone", conv_done, 0);
        tick();
        chk("last_done", conv_done, 1);
        tick();
        chk("refill_ready", s_ready_x, 1);
        chk("refill_xcount", x_count, 0);

        // X starved during SLIDE
        wait_capture(1);
        g_vx = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("slide_noacc", acc_load, 0);
            chk("slide_novalid", m_valid_y, 0);
            chk("slide_ready", s_ready_x, 1);
        end
        g_vx = 1'b1;
        tick();
        chk("slide_accept", xmem_wr_en, 1);
        tick();
        chk("slide_capture", acc_load, 1);
        chk("slide_xcount", x_count, FS + 2);
        wait_done();
        tick();

        // asynchronous reset while Y 3 is offered
        wait_capture(3);
        g_ry = 1'b0;
        tick();
        chk("pre_rst_valid", m_valid_y, 1);
        reset = 1'b0; g_rst = 1'b0;
        #1;
        chk("arst_ready", s_ready_x, 0);
        chk("arst_acc", acc_load, 0);
        chk("arst_valid", m_valid_y, 0);
        chk("arst_done", conv_done, 0);
        chk("arst_xcount", x_count, 0);
        chk("arst_yindex", y_index, 0);
        d0 = n_done;
        tick(); tick();
        chk("arst_no_done", conv_done, 0);
        chk("arst_no_done_count", n_done - d0, 0);
        g_rst = 1'b1; g_ry = 1'b1; h0 = n_hs;
        wait_done();
        chk("rerun_handshakes", n_hs - h0, NOUT);

        // random handshakes over several convolutions
        d0 = n_done;
        for (int i = 0; i < 3000; i++) begin
            g_vx = ($urandom_range(0, 3) != 0);
            g_ry = ($urandom_range(0, 2) != 0);
            g_fl = ($urandom_range(0, 7) != 0);
            tick();
            if (n_done - d0 >= 4) break;
        end
        chk("random_convs", (n_done - d0) >= 4, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
